// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM-state definitions for the alu_seq accumulator ALU.
// Also provides the legacy `OPCODE_WIDTH macro for code that still uses it.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 4
`endif

package alu_seq_pkg;

   localparam int OPCODE_W = `OPCODE_WIDTH;

   typedef logic [OPCODE_W-1:0] opcode_t;

   // Original instruction set
   localparam opcode_t OP_ADD = opcode_t'(0);
   localparam opcode_t OP_SUB = opcode_t'(1);
   localparam opcode_t OP_LD  = opcode_t'(2);
   localparam opcode_t OP_AND = opcode_t'(3);
   localparam opcode_t OP_OR  = opcode_t'(4);
   localparam opcode_t OP_XOR = opcode_t'(5);
   localparam opcode_t OP_NOT = opcode_t'(6);
   // Extensions
   localparam opcode_t OP_ADC = opcode_t'(7);
   localparam opcode_t OP_SBB = opcode_t'(8);
   localparam opcode_t OP_SHL = opcode_t'(9);
   localparam opcode_t OP_SHR = opcode_t'(10);
   localparam opcode_t OP_MUL = opcode_t'(11);

   typedef enum logic {
      ALU_ST_IDLE = 1'b0,
      ALU_ST_MULT = 1'b1
   } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one partial product per cycle, WIDTH cycles.
// start loads the operands; busy is high while stepping; last flags the final
// step, during which product already holds the complete 2*WIDTH result.
module alu_mul_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   mcand,
   input  logic [WIDTH-1:0]   mplier,
   output logic               busy,
   output logic               last,
   output logic [2*WIDTH-1:0] product
);

   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic [2*WIDTH-1:0] prod_step;
   logic               last_step;

   // Next product and step control for the current iteration
   always_comb begin
      prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
      last_step = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
      mcand_d   = mcand_q;
      prod_d    = prod_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      if (start) begin
         mcand_d  = {{WIDTH{1'b0}}, mcand};
         mplier_d = mplier;
         prod_d   = '0;
         cnt_d    = '0;
         busy_d   = 1'b1;
      end else if (busy_q) begin
         prod_d   = prod_step;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CNT_W'(1);
         if (last_step) busy_d = 1'b0;
      end
   end

   // Control is reset so an aborted multiply never reports last; data regs are reloaded on start
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
   end

   assign busy    = busy_q;
   assign last    = last_step;
   assign product = prod_step;

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit accumulator ALU with carry/zero flags and independent
// acc/flag write enables. The multi-cycle MUL opcode, the MULT state and the
// acc_hi register exist only when ALU_MUL_EN is defined; otherwise MUL is a NOP.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                op_valid,
   output logic                op_ready,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [WIDTH-1:0]    register,
   input  logic                alu_ce,
   input  logic                cy_ce,
   output logic [WIDTH-1:0]    acc,
   output logic [WIDTH-1:0]    acc_hi,
   output logic                cy,
   output logic                z,
   output logic                done
);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic             cy_q, cy_d;
   logic             z_q, z_d;
   logic             done_q, done_d;
   logic             accept;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] res;
   logic             res_c;
   logic             res_wr;

`ifdef ALU_MUL_EN
   logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
   alu_state_e         state_q, state_d;
   logic               alu_ce_q, alu_ce_d;
   logic               cy_ce_q, cy_ce_d;
   logic               mul_start;
   logic               mul_busy;
   logic               mul_last;
   logic [2*WIDTH-1:0] mul_product;

   alu_mul_seq #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .mcand   (acc_q),
      .mplier  (register),
      .busy    (mul_busy),
      .last    (mul_last),
      .product (mul_product)
   );

   assign op_ready = (state_q == ALU_ST_IDLE) && !mul_busy;
   assign acc_hi   = acc_hi_q;
`else
   assign op_ready = 1'b1;
   assign acc_hi   = '0;
`endif

   assign accept = op_valid && op_ready;

   // Single-cycle datapath: result and carry for the presented opcode
   always_comb begin
      sum    = '0;
      res    = acc_q;
      res_c  = 1'b0;
      res_wr = 1'b1;
      case (opcode)
         OP_ADD: begin
            sum   = {1'b0, acc_q} + {1'b0, register};
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
         end
         OP_ADC: begin
            sum   = {1'b0, acc_q} + {1'b0, register} + {{WIDTH{1'b0}}, cy_q};
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
         end
         // Bit WIDTH of the extended difference is the borrow
         OP_SUB: begin
            sum   = {1'b0, acc_q} - {1'b0, register};
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
         end
         OP_SBB: begin
            sum   = {1'b0, acc_q} - {1'b0, register} - {{WIDTH{1'b0}}, cy_q};
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
         end
         OP_LD:  res = register;
         OP_AND: res = acc_q & register;
         OP_OR:  res = acc_q | register;
         OP_XOR: res = acc_q ^ register;
         OP_NOT: res = ~register;
         OP_SHL: begin
            res   = acc_q << 1;
            res_c = acc_q[WIDTH-1];
         end
         OP_SHR: begin
            res   = acc_q >> 1;
            res_c = acc_q[0];
         end
         default: res_wr = 1'b0;
      endcase
   end

   // Next-state: MUL sequencing, acceptance and flag/accumulator writeback
   always_comb begin
      acc_d  = acc_q;
      cy_d   = cy_q;
      z_d    = z_q;
      done_d = 1'b0;
`ifdef ALU_MUL_EN
      acc_hi_d  = acc_hi_q;
      state_d   = state_q;
      alu_ce_d  = alu_ce_q;
      cy_ce_d   = cy_ce_q;
      mul_start = 1'b0;
      if (state_q == ALU_ST_MULT) begin
         if (mul_last) begin
            if (alu_ce_q) begin
               acc_d    = mul_product[WIDTH-1:0];
               acc_hi_d = mul_product[2*WIDTH-1:WIDTH];
               z_d      = (mul_product[WIDTH-1:0] == '0);
            end
            if (cy_ce_q) cy_d = |mul_product[2*WIDTH-1:WIDTH];
            done_d  = 1'b1;
            state_d = ALU_ST_IDLE;
         end
      end else if (accept && (opcode == OP_MUL)) begin
         mul_start = 1'b1;
         state_d   = ALU_ST_MULT;
         alu_ce_d  = alu_ce;
         cy_ce_d   = cy_ce;
      end else
`endif
      if (accept) begin
         done_d = 1'b1;
         if (res_wr) begin
            if (alu_ce) begin
               acc_d = res;
               z_d   = (res == '0);
            end
            if (cy_ce) cy_d = res_c;
         end
      end
   end

   // State registers; reset aborts any multiply in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         cy_q   <= 1'b0;
         z_q    <= 1'b1;
         done_q <= 1'b0;
`ifdef ALU_MUL_EN
         acc_hi_q <= '0;
         state_q  <= ALU_ST_IDLE;
`endif
      end else begin
         acc_q  <= acc_d;
         cy_q   <= cy_d;
         z_q    <= z_d;
         done_q <= done_d;
`ifdef ALU_MUL_EN
         acc_hi_q <= acc_hi_d;
         state_q  <= state_d;
`endif
      end
`ifdef ALU_MUL_EN
      alu_ce_q <= alu_ce_d;
      cy_ce_q  <= cy_ce_d;
`endif
   end

   assign acc  = acc_q;
   assign cy   = cy_q;
   assign z    = z_q;
   assign done = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8). Covers MUL sequencing when ALU_MUL_EN
// is defined and MUL-as-NOP otherwise.
module tb_alu_seq;
   import alu_seq_pkg::*;

   localparam int W = 8;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                op_valid = 1'b0;
   logic                op_ready;
   logic [OPCODE_W-1:0] opcode = '0;
   logic [W-1:0]        register = '0;
   logic                alu_ce = 1'b0;
   logic                cy_ce = 1'b0;
   logic [W-1:0]        acc;
   logic [W-1:0]        acc_hi;
   logic                cy;
   logic                z;
   logic                done;

   alu_seq #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .op_valid (op_valid),
      .op_ready (op_ready),
      .opcode   (opcode),
      .register (register),
      .alu_ce   (alu_ce),
      .cy_ce    (cy_ce),
      .acc      (acc),
      .acc_hi   (acc_hi),
      .cy       (cy),
      .z        (z),
      .done     (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] acc;
      logic [W-1:0] hi;
      logic         cy;
      logic         z;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_done = 0;
   int   n_expect = 0;

   logic [W-1:0] m_acc = '0;
   logic [W-1:0] m_hi = '0;
   logic         m_cy = 1'b0;
   logic         m_z = 1'b1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model of one accepted op
   task automatic model_op(input logic [OPCODE_W-1:0] op, input logic [W-1:0] v,
                           input logic ace, input logic cce);
      int           t;
      logic [W-1:0] r;
      logic         c;
      logic         wr;
      logic [15:0]  p;
      wr = 1'b1;
      c  = 1'b0;
      r  = m_acc;
      case (op)
         OP_ADD: begin t = int'(m_acc) + int'(v); r = t[W-1:0]; c = (t > 255); end
         OP_ADC: begin t = int'(m_acc) + int'(v) + int'(m_cy); r = t[W-1:0]; c = (t > 255); end
         OP_SUB: begin t = int'(m_acc) - int'(v); r = t[W-1:0]; c = (t < 0); end
         OP_SBB: begin t = int'(m_acc) - int'(v) - int'(m_cy); r = t[W-1:0]; c = (t < 0); end
         OP_LD:  r = v;
         OP_AND: r = m_acc & v;
         OP_OR:  r = m_acc | v;
         OP_XOR: r = m_acc ^ v;
         OP_NOT: r = ~v;
         OP_SHL: begin r = {m_acc[W-2:0], 1'b0}; c = m_acc[W-1]; end
         OP_SHR: begin r = {1'b0, m_acc[W-1:1]}; c = m_acc[0]; end
`ifdef ALU_MUL_EN
         OP_MUL: begin
            wr = 1'b0;
            p  = 16'(m_acc) * 16'(v);
            if (ace) begin m_acc = p[7:0]; m_hi = p[15:8]; m_z = (p[7:0] == 8'h00); end
            if (cce) m_cy = (p[15:8] != 8'h00);
         end
`endif
         default: wr = 1'b0;
      endcase
      if (wr) begin
         if (ace) begin m_acc = r; m_z = (r == '0); end
         if (cce) m_cy = c;
      end
   endtask

   // Present one op for exactly one accepting edge; returns 1 time unit after it
   task automatic issue(input logic [OPCODE_W-1:0] op, input logic [W-1:0] v,
                        input logic ace, input logic cce, input bit expect_done);
      exp_t e;
      check_eq("ready_at_issue", {31'b0, op_ready}, 32'd1);
      op_valid = 1'b1;
      opcode   = op;
      register = v;
      alu_ce   = ace;
      cy_ce    = cce;
      model_op(op, v, ace, cce);
      if (expect_done) begin
         e.acc = m_acc; e.hi = m_hi; e.cy = m_cy; e.z = m_z;
         sb_q.push_back(e);
         n_expect++;
      end
      @(posedge clk);
      #1;
      op_valid = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_acc"}, {24'b0, acc}, 32'h0);
      check_eq({tag, "_acc_hi"}, {24'b0, acc_hi}, 32'h0);
      check_eq({tag, "_cy"}, {31'b0, cy}, 32'h0);
      check_eq({tag, "_z"}, {31'b0, z}, 32'h1);
      check_eq({tag, "_done"}, {31'b0, done}, 32'h0);
      check_eq({tag, "_op_ready"}, {31'b0, op_ready}, 32'h1);
   endtask

   // Retirement monitor: every done pulse pops one expected result
   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         n_done++;
         if (sb_q.size() == 0) begin
            check_eq("done_without_op", {31'b0, done}, 32'h0);
         end else begin
            e = sb_q.pop_front();
            check_eq("sb_acc", {24'b0, acc}, {24'b0, e.acc});
            check_eq("sb_acc_hi", {24'b0, acc_hi}, {24'b0, e.hi});
            check_eq("sb_cy", {31'b0, cy}, {31'b0, e.cy});
            check_eq("sb_z", {31'b0, z}, {31'b0, e.z});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_state("reset");

      // Back-to-back LD/ADD with wrap
      issue(OP_LD, 8'hFF, 1'b1, 1'b1, 1'b1);
      check_eq("done_b2b_first", {31'b0, done}, 32'h1);
      issue(OP_ADD, 8'h01, 1'b1, 1'b1, 1'b1);
      check_eq("done_b2b_second", {31'b0, done}, 32'h1);
      check_eq("add_wrap_acc", {24'b0, acc}, 32'h00);
      check_eq("add_wrap_cy", {31'b0, cy}, 32'h1);
      check_eq("add_wrap_z", {31'b0, z}, 32'h1);

      // Carry-in arithmetic with cy preset to 1
      issue(OP_LD, 8'h0F, 1'b1, 1'b0, 1'b1);
      issue(OP_ADC, 8'h10, 1'b1, 1'b1, 1'b1);
      check_eq("adc_acc", {24'b0, acc}, 32'h20);
      check_eq("adc_cy", {31'b0, cy}, 32'h0);
      issue(OP_SBB, 8'h21, 1'b1, 1'b1, 1'b1);
      check_eq("sbb_acc", {24'b0, acc}, 32'hFF);
      check_eq("sbb_cy", {31'b0, cy}, 32'h1);

      // Flag-only write: acc and z held, carry written
      issue(OP_LD, 8'hFF, 1'b1, 1'b1, 1'b1);
      issue(OP_ADD, 8'h01, 1'b0, 1'b1, 1'b1);
      check_eq("ce_acc_held", {24'b0, acc}, 32'hFF);
      check_eq("ce_z_held", {31'b0, z}, 32'h0);
      check_eq("ce_cy_written", {31'b0, cy}, 32'h1);

      // Shifts, logic ops, subtract underflow, NOP
      issue(OP_SHL, 8'h00, 1'b1, 1'b1, 1'b1);
      issue(OP_SHR, 8'h00, 1'b1, 1'b1, 1'b1);
      issue(OP_AND, 8'h0F, 1'b1, 1'b1, 1'b1);
      issue(OP_OR,  8'hF0, 1'b1, 1'b1, 1'b1);
      issue(OP_XOR, 8'hFF, 1'b1, 1'b1, 1'b1);
      issue(OP_NOT, 8'h5A, 1'b1, 1'b1, 1'b1);
      issue(OP_LD,  8'h00, 1'b1, 1'b1, 1'b1);
      issue(OP_SUB, 8'h01, 1'b1, 1'b1, 1'b1);
      check_eq("sub_under_acc", {24'b0, acc}, 32'hFF);
      check_eq("sub_under_cy", {31'b0, cy}, 32'h1);
      issue(OP_LD,  8'h81, 1'b1, 1'b1, 1'b1);
      issue(OP_SHL, 8'h00, 1'b1, 1'b1, 1'b1);
      issue(4'hF,   8'h33, 1'b1, 1'b1, 1'b1);
      issue(OP_SHR, 8'h00, 1'b1, 1'b1, 1'b1);
      @(posedge clk);
      #1;

`ifdef ALU_MUL_EN
      // 0xFF * 0xFF with op_valid held during the busy window
      issue(OP_LD, 8'hFF, 1'b1, 1'b1, 1'b1);
      issue(OP_MUL, 8'hFF, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < W; i++) begin
         check_eq($sformatf("mul_busy_ready_%0d", i), {31'b0, op_ready}, 32'h0);
         op_valid = 1'b1;
         opcode   = OP_LD;
         register = 8'h55;
         alu_ce   = 1'b1;
         cy_ce    = 1'b1;
         @(posedge clk);
         #1;
      end
      op_valid = 1'b0;
      check_eq("mul_ready_back", {31'b0, op_ready}, 32'h1);
      check_eq("mul_done", {31'b0, done}, 32'h1);
      check_eq("mul_acc", {24'b0, acc}, 32'h01);
      check_eq("mul_acc_hi", {24'b0, acc_hi}, 32'hFE);
      check_eq("mul_cy", {31'b0, cy}, 32'h1);
      @(posedge clk);
      #1;
      check_eq("mul_done_single", {31'b0, done}, 32'h0);

      // Multiply by zero still takes WIDTH cycles
      issue(OP_LD, 8'h07, 1'b1, 1'b1, 1'b1);
      issue(OP_MUL, 8'h00, 1'b1, 1'b1, 1'b1);
      cnt = 0;
      while (!op_ready && cnt < 20) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      check_eq("mul0_latency", cnt, W);
      @(posedge clk);
      #1;

      // Reset in the middle of 0x12 * 0x34 aborts without writeback
      issue(OP_LD, 8'h12, 1'b1, 1'b1, 1'b1);
      issue(OP_MUL, 8'h34, 1'b1, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      m_acc = '0; m_hi = '0; m_cy = 1'b0; m_z = 1'b1;
      check_reset_state("mid_mul_reset");
      check_eq("sb_empty_after_rst", sb_q.size(), 32'd0);
      repeat (12) @(posedge clk);
      #1;
      check_eq("post_abort_acc", {24'b0, acc}, 32'h0);
      check_eq("post_abort_acc_hi", {24'b0, acc_hi}, 32'h0);
      check_eq("post_abort_z", {31'b0, z}, 32'h1);
`else
      // MUL decodes as a single-cycle NOP
      issue(OP_LD, 8'h05, 1'b1, 1'b1, 1'b1);
      issue(OP_MUL, 8'h03, 1'b1, 1'b1, 1'b1);
      check_eq("nomul_done", {31'b0, done}, 32'h1);
      check_eq("nomul_ready", {31'b0, op_ready}, 32'h1);
      check_eq("nomul_acc", {24'b0, acc}, 32'h05);
      check_eq("nomul_acc_hi", {24'b0, acc_hi}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check_eq($sformatf("nomul_ready_hold_%0d", i), {31'b0, op_ready}, 32'h1);
      end
`endif

      repeat (3) @(posedge clk);
      #1;
      check_eq("sb_drained", sb_q.size(), 32'd0);
      check_eq("done_count", n_done, n_expect);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
